// File: rtl/lms_fifo_sequencer.sv
// lms_fifo_sequencer: moves one sample ADC FIFO -> LMS core -> DAC FIFO, with timeout/stall/sample status.
module lms_fifo_sequencer #(
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clr_status,
  input  logic              adcfifo_empty,
  output logic              adcfifo_read,
  input  logic [DATA_W-1:0] adcfifo_readdata,
  output logic              lms_start,
  output logic [DATA_W/2-1:0] lms_ref,
  output logic [DATA_W/2-1:0] lms_pri,
  input  logic              lms_done,
  input  logic [DATA_W/2-1:0] lms_err,
  input  logic              dacfifo_full,
  output logic              dacfifo_write,
  output logic [DATA_W-1:0] dacfifo_writedata,
  output logic              busy,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  sample_count,
  output logic [CNT_W-1:0]  stall_count
);
  localparam int H  = DATA_W / 2;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {IDLE, RD, CAP, START, WAIT, WR} state_e;
  state_e state_q, state_d;
  logic [TW-1:0] wait_q, wait_d;
  logic [H-1:0] ref_q, ref_d, pri_q, pri_d, err_q, err_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic read_q, read_d, start_q, start_d, write_q, write_d, tout_q, tout_d;
  logic [CNT_W-1:0] scnt_q, scnt_d, stall_q, stall_d;
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    ref_d   = ref_q;
    pri_d   = pri_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    write_d = 1'b0;
    tout_d  = tout_q;
    scnt_d  = scnt_q;
    stall_d = stall_q;
    case (state_q)
      IDLE:  state_d = (enable && !adcfifo_empty) ? RD : IDLE;
      RD:    state_d = CAP;
      CAP: begin
        {ref_d, pri_d} = adcfifo_readdata;
        state_d = START;
      end
      START: begin
        wait_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // done takes precedence over a timeout landing in the same cycle
        if (lms_done) begin
          err_d   = lms_err;
          state_d = WR;
        end else begin
          wait_d = wait_q + 1'b1;
          if (wait_d == TW'(TIMEOUT_CYC)) begin
            tout_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WR: begin
        if (!dacfifo_full) begin
          write_d = 1'b1;
          wdata_d = {err_q, pri_q};
          scnt_d  = scnt_q + 1'b1;
          state_d = IDLE;
        end else begin
          stall_d = (stall_q == '1) ? stall_q : stall_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clr_status) begin
      tout_d  = 1'b0;
      stall_d = '0;
    end
    read_d  = (state_d == RD);
    start_d = (state_d == START);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wait_q  <= '0;
      ref_q   <= '0;
      pri_q   <= '0;
      err_q   <= '0;
      wdata_q <= '0;
      read_q  <= 1'b0;
      start_q <= 1'b0;
      write_q <= 1'b0;
      tout_q  <= 1'b0;
      scnt_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ref_q   <= ref_d;
      pri_q   <= pri_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
      read_q  <= read_d;
      start_q <= start_d;
      write_q <= write_d;
      tout_q  <= tout_d;
      scnt_q  <= scnt_d;
      stall_q <= stall_d;
    end
  end
  assign adcfifo_read      = read_q;
  assign lms_start         = start_q;
  assign lms_ref           = ref_q;
  assign lms_pri           = pri_q;
  assign dacfifo_write     = write_q;
  assign dacfifo_writedata = wdata_q;
  assign busy              = (state_q != IDLE);
  assign timeout_err       = tout_q;
  assign sample_count      = scnt_q;
  assign stall_count       = stall_q;
endmodule

// File: tb/tb_lms_fifo_sequencer.sv
// tb_lms_fifo_sequencer: directed steps with ADC FIFO / LMS models and a DAC write scoreboard.
module tb_lms_fifo_sequencer;
  logic clk = 0, rst = 1, enable = 0, clr_status = 0, adcfifo_empty = 1, lms_done = 0, dacfifo_full = 0;
  logic [31:0] adcfifo_readdata = 0;
  logic [15:0] lms_err = 0;
  logic adcfifo_read, lms_start, dacfifo_write, busy, timeout_err;
  logic [15:0] lms_ref, lms_pri, sample_count, stall_count;
  logic [31:0] dacfifo_writedata;
  logic adcfifo_read2, lms_start2, dacfifo_write2, busy2, timeout_err2;
  logic [15:0] lms_ref2, lms_pri2;
  logic [31:0] dacfifo_writedata2;
  logic [2:0] sample_count2, stall_count2;

  lms_fifo_sequencer #(.DATA_W(32), .CNT_W(16), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clr_status(clr_status),
    .adcfifo_empty(adcfifo_empty), .adcfifo_read(adcfifo_read), .adcfifo_readdata(adcfifo_readdata),
    .lms_start(lms_start), .lms_ref(lms_ref), .lms_pri(lms_pri), .lms_done(lms_done), .lms_err(lms_err),
    .dacfifo_full(dacfifo_full), .dacfifo_write(dacfifo_write), .dacfifo_writedata(dacfifo_writedata),
    .busy(busy), .timeout_err(timeout_err), .sample_count(sample_count), .stall_count(stall_count));

  // narrow-counter twin on the same stimulus exposes wrap and saturation
  lms_fifo_sequencer #(.DATA_W(32), .CNT_W(3), .TIMEOUT_CYC(16)) dut2 (
    .clk(clk), .rst(rst), .enable(enable), .clr_status(clr_status),
    .adcfifo_empty(adcfifo_empty), .adcfifo_read(adcfifo_read2), .adcfifo_readdata(adcfifo_readdata),
    .lms_start(lms_start2), .lms_ref(lms_ref2), .lms_pri(lms_pri2), .lms_done(lms_done), .lms_err(lms_err),
    .dacfifo_full(dacfifo_full), .dacfifo_write(dacfifo_write2), .dacfifo_writedata(dacfifo_writedata2),
    .busy(busy2), .timeout_err(timeout_err2), .sample_count(sample_count2), .stall_count(stall_count2));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  logic [31:0] adc_q[$];
  logic [31:0] sb_q[$];
  logic [31:0] last_word = 0;
  bit use_fix = 0;
  int lat = 1, cd = 0, cyc = 0, rd_cyc = 0, wr_cyc = 0, wr_cnt = 0, last_wr = 0, wr_gap = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic push(input logic [31:0] w, input bit keep);
    adc_q.push_back(w);
    adcfifo_empty = 0;
    if (keep) sb_q.push_back({use_fix ? 16'h0F0F : (w[31:16] ^ w[15:0]), w[15:0]});
  endtask

  task automatic wait_wr(input int target, input int budget);
    int b = budget;
    while (wr_cnt < target && b > 0) begin tick(1); b--; end
    chk("write_count", wr_cnt, target);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (adcfifo_read) begin
      chk("read_nonempty", adc_q.size() != 0, 1);
      if (adc_q.size() != 0) begin
        last_word = adc_q.pop_front();
        adcfifo_readdata = last_word;
      end
      rd_cyc = cyc;
    end
    adcfifo_empty = (adc_q.size() == 0);
    lms_done = 0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) lms_done = 1;
    end
    if (lms_start) begin
      chk("start_ref", lms_ref, last_word[31:16]);
      chk("start_pri", lms_pri, last_word[15:0]);
      if (lat > 0) cd = lat;
    end
    lms_err = use_fix ? 16'h0F0F : (last_word[31:16] ^ last_word[15:0]);
    if (dacfifo_write) begin
      wr_cnt++;
      wr_gap = cyc - last_wr;
      last_wr = cyc;
      wr_cyc = cyc;
      if (sb_q.size() == 0) chk("unexpected_write", dacfifo_write, 0);
      else chk("write_data", dacfifo_writedata, sb_q.pop_front());
    end
  end

  initial begin
    int b, n;
    tick(3);
    chk("rst_read", adcfifo_read, 0);
    chk("rst_start", lms_start, 0);
    chk("rst_ops", {lms_ref, lms_pri}, 0);
    chk("rst_write", dacfifo_write, 0);
    chk("rst_wdata", dacfifo_writedata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_status", {timeout_err, sample_count, stall_count}, 0);
    rst = 0;
    enable = 1;
    // single sample
    use_fix = 1;
    push(32'h1234ABCD, 1);
    wait_wr(1, 40);
    chk("rd_to_wr", wr_cyc - rd_cyc, 5);
    chk("hold_ref", lms_ref, 16'h1234);
    chk("hold_pri", lms_pri, 16'hABCD);
    chk("wdata_hold", dacfifo_writedata, 32'h0F0FABCD);
    chk("count1", sample_count, 1);
    use_fix = 0;
    // back-to-back, done latency 3
    lat = 3;
    for (int i = 0; i < 8; i++) push(32'hA5000000 + 32'(i * 32'h00110203), 1);
    for (int i = 0; i < 8; i++) begin
      wait_wr(2 + i, 40);
      if (i > 0) chk("b2b_gap", wr_gap, 8);
    end
    chk("count9", sample_count, 9);
    chk("count_wrap", sample_count2, 1);
    // backpressure
    lat = 1;
    dacfifo_full = 1;
    push(32'hDEAD0001, 1);
    b = 0;
    while (stall_count != 10 && b < 40) begin tick(1); b++; end
    chk("stall_10", stall_count, 10);
    chk("no_write_full", wr_cnt, 9);
    dacfifo_full = 0;
    wait_wr(10, 5);
    chk("stall_hold", stall_count, 10);
    chk("stall_sat", stall_count2, 7);
    clr_status = 1;
    tick(1);
    clr_status = 0;
    chk("stall_clr", stall_count, 0);
    // timeout with done never arriving
    lat = 0;
    push(32'h0BAD0BAD, 0);
    b = 0;
    while (!busy && b < 10) begin tick(1); b++; end
    n = 0;
    while (busy && n < 60) begin tick(1); n++; end
    chk("to_busy_cycles", n, 19);
    chk("to_err", timeout_err, 1);
    chk("to_no_write", wr_cnt, 10);
    chk("to_count", sample_count, 10);
    lat = 1;
    push(32'h22223333, 1);
    wait_wr(11, 30);
    chk("to_sticky", timeout_err, 1);
    clr_status = 1;
    tick(1);
    clr_status = 0;
    chk("to_clr", timeout_err, 0);
    // done exactly on the limit cycle
    lat = 16;
    push(32'h44445555, 1);
    wait_wr(12, 50);
    chk("limit_no_to", timeout_err, 0);
    chk("count12", sample_count, 12);
    // enable dropped mid-sample
    lat = 3;
    push(32'h66667777, 1);
    push(32'h88889999, 1);
    b = 0;
    while (!lms_start && b < 20) begin tick(1); b++; end
    chk("start_seen", lms_start, 1);
    tick(1);
    enable = 0;
    wait_wr(13, 20);
    tick(20);
    chk("en_no_more", wr_cnt, 13);
    chk("en_idle", busy, 0);
    chk("en_fifo_left", adc_q.size(), 1);
    enable = 1;
    wait_wr(14, 30);
    chk("count14", sample_count, 14);
    chk("count14_wrap", sample_count2, 6);
    // reset while stalled in WR
    lat = 1;
    dacfifo_full = 1;
    push(32'hCAFEF00D, 1);
    b = 0;
    while (stall_count != 2 && b < 30) begin tick(1); b++; end
    chk("wr_stalled", stall_count, 2);
    rst = 1;
    tick(1);
    chk("rr_write", dacfifo_write, 0);
    chk("rr_busy", busy, 0);
    chk("rr_wdata", dacfifo_writedata, 0);
    chk("rr_ops", {lms_ref, lms_pri}, 0);
    chk("rr_status", {timeout_err, sample_count, stall_count}, 0);
    rst = 0;
    dacfifo_full = 0;
    void'(sb_q.pop_back());
    tick(10);
    chk("rr_dropped", wr_cnt, 14);
    chk("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lms_fifo_sequencer.md
Name: lms_fifo_sequencer

Overview:
- Sequences the LMS noise-cancellation datapath, one sample at a time: pops a packed sample word from the ADC FIFO, hands it to the LMS filter core with a start/done handshake, then pushes the result word into the DAC FIFO.
- Sits between the ADC FIFO read port, the LMS core and the DAC FIFO write port. Provides timeout, stall and sample-count status for debug probing.

Parameters:
- DATA_W, 32, FIFO word width; lower half = primary (noisy) channel, upper half = reference noise channel
- CNT_W, 16, width of sample and stall counters
- TIMEOUT_CYC, 1023, maximum cycles spent waiting for lms_done before the sample is dropped

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- enable  in  1  run request; sampled in IDLE only
- clr_status  in  1  one-cycle pulse; clears timeout_err and stall_count
- adcfifo_empty  in  1  ADC FIFO empty flag
- adcfifo_read  out  1  ADC FIFO read strobe
- adcfifo_readdata  in  DATA_W  ADC FIFO data, valid 1 cycle after adcfifo_read
- lms_start  out  1  one-cycle start pulse to LMS core
- lms_ref  out  DATA_W/2  reference operand = adcfifo_readdata[DATA_W-1:DATA_W/2]
- lms_pri  out  DATA_W/2  primary operand = adcfifo_readdata[DATA_W/2-1:0]
- lms_done  in  1  LMS result valid pulse
- lms_err  in  DATA_W/2  LMS error output (cleaned signal), valid with lms_done
- dacfifo_full  in  1  DAC FIFO full flag
- dacfifo_write  out  1  DAC FIFO write strobe
- dacfifo_writedata  out  DATA_W  {lms_err, lms_pri}
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  sticky; set on LMS timeout
- sample_count  out  CNT_W  samples written to the DAC FIFO, wraps modulo 2^CNT_W
- stall_count  out  CNT_W  cycles spent blocked by dacfifo_full, saturating

Behaviour:
- Reset (sync): state=IDLE; every output 0; operand, result, counter and flag registers 0. Reset mid-sample aborts immediately: no write, no count.
- All strobes are registered decodes of the state.
- FSM states:
  - IDLE: if enable && !adcfifo_empty -> RD, else stay.
  - RD: adcfifo_read=1 for exactly this cycle -> CAP.
  - CAP: latch adcfifo_readdata into lms_ref/lms_pri -> START.
  - START: lms_start=1 for one cycle; clear wait counter -> WAIT.
  - WAIT: on lms_done, latch lms_err -> WR. Otherwise increment the wait counter; when it reaches TIMEOUT_CYC without done: set timeout_err, drop the sample (no write, no count) -> IDLE. If lms_done arrives in the same cycle as the limit, done wins.
  - WR: if !dacfifo_full, dacfifo_write=1 for exactly one cycle, dacfifo_writedata={lms_err, lms_pri}, sample_count+1 -> IDLE. Otherwise hold, stall_count+1 (saturate at all-ones).
- lms_ref/lms_pri hold stable from START until the next CAP.
- dacfifo_writedata holds its last value after the write.
- lms_done outside WAIT is ignored.
- Minimum 6 cycles/sample: IDLE, RD, CAP, START, WAIT (done at START+1), WR.
- enable low mid-sample: the current sample completes, then the FSM stays in IDLE.
- adcfifo_read never asserts while adcfifo_empty=1 was seen in IDLE.
- dacfifo_write never asserts while dacfifo_full=1.
- clr_status has priority over a same-cycle set/increment of timeout_err/stall_count; sample_count is cleared only by rst.
- busy = (state != IDLE).

Test Plan:
- Single sample: ADC word 0x1234_ABCD, lms_done one cycle after lms_start with lms_err=0x0F0F -> lms_ref=0x1234, lms_pri=0xABCD; one dacfifo_write with 0x0F0F_ABCD exactly 5 cycles after adcfifo_read; sample_count=1.
- Back-to-back: 8 queued words, LMS done latency 3 -> 8 writes in order, data matches, one write per 8 cycles, sample_count=8, no reads while empty.
- Backpressure: dacfifo_full held for 10 cycles in WR -> no write during those cycles, stall_count=10, write on the first non-full cycle; clr_status -> stall_count=0.
- Timeout: TIMEOUT_CYC=16, lms_done never asserted -> timeout_err=1 after 16 WAIT cycles, no DAC write, sample_count unchanged, next sample processed normally. lms_done on exactly cycle 16 -> write occurs, timeout_err stays 0.
- Enable/reset: drop enable during WAIT -> the sample completes, no further reads. Assert rst in WR while full -> next cycle all outputs 0, state IDLE, no write.
- Counter wrap: preload via 65536 samples with CNT_W=16 -> sample_count wraps to 0.
